// File: rtl/bcd_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_scan_display: multiplexed active-low 7-segment scanner with per-frame   |
// | snapshot, anti-ghost blank slot, leading-zero suppression. Rev 1.0          |
// +----------------------------------------------------------------------------+
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2,
  parameter int SCAN_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int                PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;
  logic                    snap_ld;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    lz_run;
  logic [6:0]              dec;

  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    snap_ld = 1'b0;
    if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          tick_d  = 1'b1;
          snap_ld = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Walk from the most significant digit down so lz_run marks "all zero from here up".
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (snap_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        cur_digit = snap_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        cur_lz    = lz_run && (i != 0);
      end
    end
  end

  always_comb begin
    case (cur_digit)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b1111110;
    endcase
  end

  always_comb begin
    seg_d = (blank_lz && cur_lz) ? 7'h7F : dec;
    dp_d  = ~cur_dp;
    an_d  = (pre_q == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q     <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
      snap_q    <= digits;
      snap_dp_q <= dp_in;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
      if (snap_ld) begin
        snap_q    <= digits;
        snap_dp_q <= dp_in;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// Testbench for bcd_scan_display: directed vector table plus multi-cycle corner sequences.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.NUM_DIGITS(4), .IDX_W(2), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      dpi;
    logic            bl;
    logic [3:0][6:0] segs;   // expected seg per slot, index = digit
    logic [3:0]      dpx;    // expected active-low dp per slot
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Edge n (1-based since reset release) with en held high throughout.
  task automatic step_check(input int n, input logic [3:0][6:0] segs, input logic [3:0] dpx);
    int         pb;
    int         ib;
    logic [3:0] e_an;
    logic [3:0] one;
    @(posedge clk); #1;
    pb   = (n - 1) % 4;
    ib   = ((n - 1) / 4) % 4;
    one  = 4'b0001;
    e_an = (pb == 0) ? 4'hF : ~(one << ib);
    chk($sformatf("an@%0d", n),   32'(an),         32'(e_an));
    chk($sformatf("seg@%0d", n),  32'(seg),        32'(segs[ib]));
    chk($sformatf("dp@%0d", n),   32'(dp),         32'(dpx[ib]));
    chk($sformatf("tick@%0d", n), 32'(frame_tick), 32'((n % 16) == 0));
    chk($sformatf("idx@%0d", n),  32'(digit_idx),  32'((n / 4) % 4));
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [3:0] dpi, input logic bl, input int cyc);
    clr = 1'b1; en = 1'b0; digits = d; dp_in = dpi; blank_lz = bl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"},   32'(an),         32'hF);
    chk({tag, "_seg"},  32'(seg),        32'h7F);
    chk({tag, "_dp"},   32'(dp),         32'h1);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    chk({tag, "_idx"},  32'(digit_idx),  32'h0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h0F, 7'h01}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1011};
    vecs[3] = '{16'h00AF, 4'b0000, 1'b0, {7'h01, 7'h01, 7'h7E, 7'h7E}, 4'b1111};
    vecs[4] = '{16'h0070, 4'b0000, 1'b0, {7'h01, 7'h01, 7'h0F, 7'h01}, 4'b1111};
    vecs[5] = '{16'h5678, 4'b1010, 1'b0, {7'h24, 7'h20, 7'h0F, 7'h00}, 4'b0101};
    vecs[6] = '{16'h0905, 4'b0000, 1'b1, {7'h7F, 7'h04, 7'h01, 7'h24}, 4'b1111};

    // Reset held two cycles with en low
    do_reset(16'h1234, 4'b0000, 1'b0, 2);
    chk_reset_state("reset");

    // Table-driven single frames, each starting from a fresh snapshot taken during clr
    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].d, vecs[v].dpi, vecs[v].bl, 1);
      clr = 1'b0; en = 1'b1;
      for (int n = 1; n <= 16; n++) step_check(n, vecs[v].segs, vecs[v].dpx);
    end

    // Mid-frame digit change only shows after the frame boundary
    do_reset(16'h1234, 4'b0000, 1'b0, 1);
    clr = 1'b0; en = 1'b1;
    for (int n = 1; n <= 5; n++) step_check(n, vecs[0].segs, vecs[0].dpx);
    digits = 16'h5678;
    for (int n = 6; n <= 16; n++) step_check(n, vecs[0].segs, vecs[0].dpx);
    for (int n = 17; n <= 32; n++) step_check(n, {7'h24, 7'h20, 7'h0F, 7'h00}, 4'b1111);

    // en low mid-slot freezes position on digit 1 (pre=2)
    do_reset(16'h00AF, 4'b0000, 1'b0, 1);
    clr = 1'b0; en = 1'b1;
    for (int n = 1; n <= 6; n++) step_check(n, vecs[3].segs, vecs[3].dpx);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("frz_an%0d", k),   32'(an),         32'hD);
      chk($sformatf("frz_seg%0d", k),  32'(seg),        32'h7E);
      chk($sformatf("frz_idx%0d", k),  32'(digit_idx),  32'h1);
      chk($sformatf("frz_tick%0d", k), 32'(frame_tick), 32'h0);
    end
    en = 1'b1;
    for (int n = 7; n <= 16; n++) step_check(n, vecs[3].segs, vecs[3].dpx);

    // clr mid-frame at digit_idx=2, pre=2, with en still high
    do_reset(16'h1234, 4'b0000, 1'b0, 1);
    clr = 1'b0; en = 1'b1;
    for (int n = 1; n <= 10; n++) step_check(n, vecs[0].segs, vecs[0].dpx);
    clr = 1'b1; digits = 16'h5678; dp_in = 4'b0001;
    @(posedge clk); #1;
    chk_reset_state("midclr");
    clr = 1'b0;
    for (int n = 1; n <= 16; n++) step_check(n, {7'h24, 7'h20, 7'h0F, 7'h00}, 4'b1110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
